// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/data_mem_arbiter_pick2.sv
// Combinational 2-way picker; DATA_MEM_ARB_RR_EN selects round-robin on ties, else port 0 wins.
module arb_pick2
  import data_mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_o,
  output logic vld_o
);

`ifndef DATA_MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    vld_o = req0_i | req1_i;
    gnt_o = PORT_LSU;
    if (req0_i && req1_i) begin
`ifdef DATA_MEM_ARB_RR_EN
      // Tie goes to whichever port did not win last time.
      gnt_o = (last_i == PORT_DBG) ? PORT_LSU : PORT_DBG;
`else
      gnt_o = PORT_LSU;
`endif
    end else if (req1_i) begin
      gnt_o = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port req/ack arbiter for the data memory: ack 2 cycles after sample (1 for range errors).
// Losing port stays pending; DATA_MEM_ARB_RR_EN enables round-robin tie breaking.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  arb_state_e        state_q;
  logic              port_q;
  logic              we_q;
  logic [1:0]        ack_q;
  logic [1:0]        err_q;
  logic [1:0]        rd_sel_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              last_win;
  logic              gnt_idx;
  logic              gnt_vld;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= PORT_DBG;
    end else if (state_q == IDLE && gnt_vld) begin
      last_q <= gnt_idx;
    end
  end

  assign last_win = last_q;
`else
  assign last_win = PORT_DBG;
`endif

  arb_pick2 u_pick (
    .req0_i (p0_req_i),
    .req1_i (p1_req_i),
    .last_i (last_win),
    .gnt_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

  assign sel_we    = gnt_idx ? p1_we_i    : p0_we_i;
  assign sel_addr  = gnt_idx ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = gnt_idx ? p1_wdata_i : p0_wdata_i;
  assign in_range  = ({1'b0, sel_addr} < DEPTH_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      port_q      <= PORT_LSU;
      we_q        <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      rd_sel_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack_q       <= '0;
      err_q       <= '0;
      rd_sel_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            port_q <= gnt_idx;
            we_q   <= sel_we;
            if (in_range) begin
              state_q     <= ACCESS;
              mem_read_q  <= ~sel_we;
              mem_write_q <= sel_we;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              // Out-of-range requests bypass the memory entirely.
              state_q        <= RESP;
              ack_q[gnt_idx] <= 1'b1;
              err_q[gnt_idx] <= 1'b1;
            end
          end
        end
        ACCESS: begin
          state_q         <= RESP;
          ack_q[port_q]   <= 1'b1;
          rd_sel_q[port_q] <= ~we_q;
          mem_addr_q      <= '0;
          mem_wdata_q     <= '0;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory returns read data in the ack cycle, so rdata is a registered-select gate.
  assign p0_rdata_o  = rd_sel_q[0] ? mem_rdata_i : '0;
  assign p1_rdata_o  = rd_sel_q[1] ? mem_rdata_i : '0;
  assign p0_ack_o    = ack_q[0];
  assign p1_ack_o    = ack_q[1];
  assign p0_err_o    = err_q[0];
  assign p1_err_o    = err_q[1];
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 8-entry memory.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p0_err, p1_ack, p1_err;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mem [8];
  logic prev_p0_ack = 1'b0;
  logic prev_p1_ack = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p0_ack_o    (p0_ack),
    .p0_err_o    (p0_err),
    .p0_rdata_o  (p0_rdata),
    .p1_ack_o    (p1_ack),
    .p1_err_o    (p1_err),
    .p1_rdata_o  (p1_rdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[2:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[2:0]];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      miscompares++; $display("FAIL strobes: read=%b write=%b, required not both", mem_read, mem_write);
    end
    if (p0_ack && p1_ack) begin
      miscompares++; $display("FAIL dual_ack: p0_ack=%b p1_ack=%b, required one at most", p0_ack, p1_ack);
    end
    if ((p0_ack && prev_p0_ack) || (p1_ack && prev_p1_ack)) begin
      miscompares++; $display("FAIL ack_width: ack held 2 cycles, required 1");
    end
    if (!p0_ack && (p0_err || p0_rdata != 8'h00)) begin
      miscompares++; $display("FAIL p0_idle_out: err=%b rdata=%h, required 0/00", p0_err, p0_rdata);
    end
    if (!p1_ack && (p1_err || p1_rdata != 8'h00)) begin
      miscompares++; $display("FAIL p1_idle_out: err=%b rdata=%h, required 0/00", p1_err, p1_rdata);
    end
    prev_p0_ack = p0_ack;
    prev_p1_ack = p1_ack;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1, "timeout");
  end

  task automatic run_txn(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, output int lat, output logic ack_port,
                         output logic [7:0] rdata, output logic err, output int nrd,
                         output int nwr, output logic [7:0] saddr, output logic [7:0] sdat);
    logic done;
    lat = 0; ack_port = 1'b0; rdata = 8'h00; err = 1'b0;
    nrd = 0; nwr = 0; saddr = 8'h00; sdat = 8'h00; done = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_read)  begin nrd++; saddr = mem_addr; end
      if (mem_write) begin nwr++; saddr = mem_addr; sdat = mem_wdata; end
      if (p0_ack || p1_ack) begin
        done = 1'b1;
        ack_port = p1_ack;
        rdata = p1_ack ? p1_rdata : p0_rdata;
        err = p1_ack ? p1_err : p0_err;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    vectors++; if (mem_read !== 1'b0)  begin miscompares++; $display("FAIL rst_mem_read: got %b, required 0", mem_read); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_mem_write: got %b, required 0", mem_write); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_mem_addr: got %h, required 00", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_mem_wdata: got %h, required 00", mem_wdata); end
    vectors++; if ({p0_ack, p1_ack, p0_err, p1_err} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_ack_err: got %b, required 0000", {p0_ack, p1_ack, p0_err, p1_err});
    end
    vectors++; if ({p0_rdata, p1_rdata} !== 16'h0000) begin
      miscompares++; $display("FAIL rst_rdata: got %h, required 0000", {p0_rdata, p1_rdata});
    end
  endtask

  task automatic test_read();
    int lat, nrd, nwr; logic ap, err; logic [7:0] rd, sa, sd;
    run_txn(1'b0, 1'b0, 8'd3, 8'h00, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d, required 2", lat); end
    vectors++; if (ap !== 1'b0) begin miscompares++; $display("FAIL rd_ack_port: got %b, required 0", ap); end
    vectors++; if (rd !== 8'h03) begin miscompares++; $display("FAIL rd_rdata: got %h, required 03", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b, required 0", err); end
    vectors++; if (nrd !== 1 || nwr !== 0) begin
      miscompares++; $display("FAIL rd_strobes: got rd=%0d wr=%0d, required 1/0", nrd, nwr);
    end
    vectors++; if (sa !== 8'd3) begin miscompares++; $display("FAIL rd_mem_addr: got %h, required 03", sa); end
  endtask

  task automatic test_write_readback();
    int lat, nrd, nwr; logic ap, err; logic [7:0] rd, sa, sd;
    run_txn(1'b1, 1'b1, 8'd5, 8'hA5, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d, required 2", lat); end
    vectors++; if (ap !== 1'b1) begin miscompares++; $display("FAIL wr_ack_port: got %b, required 1", ap); end
    vectors++; if (nwr !== 1 || nrd !== 0) begin
      miscompares++; $display("FAIL wr_strobes: got rd=%0d wr=%0d, required 0/1", nrd, nwr);
    end
    vectors++; if (sa !== 8'd5 || sd !== 8'hA5) begin
      miscompares++; $display("FAIL wr_addr_data: got %h/%h, required 05/a5", sa, sd);
    end
    vectors++; if (rd !== 8'h00 || err !== 1'b0) begin
      miscompares++; $display("FAIL wr_resp: got rdata=%h err=%b, required 00/0", rd, err);
    end
    run_txn(1'b0, 1'b0, 8'd5, 8'h00, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (rd !== 8'hA5 || ap !== 1'b0) begin
      miscompares++; $display("FAIL readback: got rdata=%h port=%b, required a5/0", rd, ap);
    end
  endtask

  task automatic test_error();
    int lat, nrd, nwr; logic ap, err; logic [7:0] rd, sa, sd;
    run_txn(1'b0, 1'b0, 8'd8, 8'h00, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL err_latency: got %0d, required 1", lat); end
    vectors++; if (err !== 1'b1 || ap !== 1'b0) begin
      miscompares++; $display("FAIL err_flag: got err=%b port=%b, required 1/0", err, ap);
    end
    vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL err_rdata: got %h, required 00", rd); end
    vectors++; if (nrd !== 0 || nwr !== 0) begin
      miscompares++; $display("FAIL err_strobes: got rd=%0d wr=%0d, required 0/0", nrd, nwr);
    end
    run_txn(1'b1, 1'b1, 8'hFF, 8'h5A, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (lat !== 1 || err !== 1'b1 || ap !== 1'b1 || nwr !== 0) begin
      miscompares++; $display("FAIL err_p1_write: got lat=%0d err=%b port=%b wr=%0d, required 1/1/1/0",
                              lat, err, ap, nwr);
    end
    vectors++; if (mem[7] !== 8'h07) begin miscompares++; $display("FAIL err_no_write: mem7=%h, required 07", mem[7]); end
  endtask

  task automatic test_tie();
    logic [3:0] seq, exp_seq;
    int ack_cyc [4];
    int n, cyc;
    logic bad_rd;
    seq = 4'b0000; n = 0; cyc = 0; bad_rd = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd1; p0_wdata = 8'h00;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd2; p1_wdata = 8'h00;
    while (n < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack || p1_ack) begin
        seq[n] = p1_ack;
        ack_cyc[n] = cyc;
        if (p0_ack && p0_rdata !== 8'h01) bad_rd = 1'b1;
        if (p1_ack && p1_rdata !== 8'h02) bad_rd = 1'b1;
        n++;
      end
    end
    p0_req = 1'b0;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL tie_count: got %0d acks, required 4", n); end
    vectors++; if (seq !== exp_seq) begin miscompares++; $display("FAIL tie_order: got %b, required %b", seq, exp_seq); end
    vectors++; if (bad_rd) begin miscompares++; $display("FAIL tie_rdata: got wrong read data, required 01/02"); end
    vectors++; if (n == 4 && (ack_cyc[0] != 2 || ack_cyc[1] != 5 || ack_cyc[3] != 11)) begin
      miscompares++; $display("FAIL tie_spacing: got %0d,%0d,%0d, required 2,5,11", ack_cyc[0], ack_cyc[1], ack_cyc[3]);
    end
    n = 0; cyc = 0;
    while (n < 1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack) begin n++; seq[0] = 1'b0; end
      if (p1_ack) begin n++; seq[0] = 1'b1; end
    end
    p1_req = 1'b0;
    vectors++; if (n !== 1 || seq[0] !== 1'b1 || cyc !== 3) begin
      miscompares++; $display("FAIL tie_pending_p1: got acks=%0d port=%b cyc=%0d, required 1/1/3", n, seq[0], cyc);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nrd, nwr, stray; logic ap, err; logic [7:0] rd, sa, sd;
    stray = 0;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd4; p0_wdata = 8'h00;
    @(posedge clk); #1;
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 8'd4) begin
      miscompares++; $display("FAIL mid_access: got read=%b addr=%h, required 1/04", mem_read, mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    vectors++; if ({mem_read, mem_write, p0_ack, p1_ack} !== 4'b0000 || mem_addr !== 8'h00) begin
      miscompares++; $display("FAIL mid_async_clear: got %b addr=%h, required 0000/00",
                              {mem_read, mem_write, p0_ack, p1_ack}, mem_addr);
    end
    p0_req = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack || mem_read || mem_write) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL mid_stray: got %0d active cycles, required 0", stray); end
    run_txn(1'b0, 1'b0, 8'd4, 8'h00, lat, ap, rd, err, nrd, nwr, sa, sd);
    vectors++; if (lat !== 2 || rd !== 8'h04 || err !== 1'b0 || ap !== 1'b0) begin
      miscompares++; $display("FAIL mid_fresh: got lat=%0d rdata=%h err=%b port=%b, required 2/04/0/0",
                              lat, rd, err, ap);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    mem_rdata = 8'h00;
    reset = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    #12;
    test_reset();
    @(posedge clk); #2 reset = 1'b1;
    test_read();
    test_write_readback();
    test_error();
    test_tie();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer for the 8-entry, 8-bit data memory. It lets two requesters share the single memory port through a req/ack handshake: port 0 is the load/store unit and port 1 is the debug/initialisation loader. It drives the memory's `mem_read`/`mem_write`/`addr`/`write_data` pins and returns read data with a one-cycle acknowledge.

## Interface
- `ADDR_W`, default 8: address width of ports and memory.
- `DATA_W`, default 8: data width.
- `DEPTH`, default 8: implemented memory entries; addresses ≥ `DEPTH` are errors.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request; held high until the matching ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `p0_addr`, `p1_addr`  in  `ADDR_W`  address; stable while req is high.
- `p0_wdata`, `p1_wdata`  in  `DATA_W`  write data; stable while req is high.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  valid with ack; 1 = address out of range.
- `p0_rdata`, `p1_rdata`  out  `DATA_W`  read data, valid with ack on reads.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  `ADDR_W`  memory address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `mem_rdata`  in  `DATA_W`  memory read data; the memory registers it on the clock edge where `mem_read` is sampled.

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- **IDLE.** If any request is high:
  - Pick a winner and latch its we/addr/wdata and port index.
  - If addr < `DEPTH`, go to ACCESS. Otherwise go to RESP with an error flag set and no memory access.
- **ACCESS.** Drive `mem_addr`/`mem_wdata` from the latch.
  - Assert exactly one of `mem_read`/`mem_write` for this single cycle.
  - Go to RESP.
- **RESP.** Pulse the winner's ack for one cycle.
  - Reads: `rdata` = `mem_rdata`, `err` = 0.
  - Writes: `rdata` = 0.
  - Errors: `err` = 1, `rdata` = 0.
  - Go to IDLE.
- **Simultaneous requests** (both high in IDLE): the winner is chosen per Configuration. The loser stays pending and is served in the next transaction.
- Only the granted port ever sees ack or err; the other port's ack, err and rdata stay 0.
- **Reset values:** all `mem_*`, ack, err and rdata outputs = 0; state = IDLE; round-robin pointer = "port 1 last".
- **Reset mid-transaction:** abort immediately. No ack is issued and no memory strobe is asserted after reset release until a new request arrives.
- A requester that drops req before ack is a protocol violation. The transaction still completes and the ack is still issued.

## Timing
- Request sampled at edge k → ACCESS during cycle k+1 → ack during cycle k+2. Latency is 2 cycles from sample to ack.
- Error requests skip ACCESS: ack/err during cycle k+1.
- The requester must deassert req at the edge ending its ack cycle, or issue its next request then.
- The arbiter returns to IDLE at that same edge and samples requests again on the following edge.
- Peak throughput: one transaction every 3 cycles; every 2 cycles for errors.
- `mem_read` and `mem_write` are never high together and are never high outside ACCESS.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined: round-robin. On a tie, the port that did not win the previous granted transaction wins; the pointer updates on every grant.
  - After reset, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins a tie. No pointer register exists.

## Structure
- Package `data_mem_arb_pkg` holds:
  - the state enum typedef (IDLE/ACCESS/RESP);
  - port index constants `PORT_LSU` = 0 and `PORT_DBG` = 1;
  - default `ADDR_W`/`DATA_W`/`DEPTH`.
- Sub-module `arb_pick2`: a combinational 2-way picker. Inputs are the two requests and the last winner; outputs are the grant index and a valid flag. The RR/fixed selection under the macro lives there.
- The FSM, latches and response muxing stay in the top module.

## Test plan
- Reset release, p0 read addr 3 (memory holds 3) → `mem_read` high in cycle k+1 with `mem_addr`=3; `p0_ack`=1, `p0_rdata`=3, `p0_err`=0 in cycle k+2.
- p1 write addr 5 data 0xA5, then p0 read addr 5 → exactly one `mem_write` cycle with addr 5 / data 0xA5; then `p0_rdata`=0xA5.
- p0 and p1 both request continuously.
  - With RR: grants alternate p0, p1, p0, p1.
  - Without the macro: p0 wins every tie until it drops its request.
- p0 read addr 8 → `p0_ack`=1 with `p0_err`=1 and `p0_rdata`=0 in cycle k+1; `mem_read`/`mem_write` never asserted.
- Reset asserted during ACCESS → all outputs 0 asynchronously; no ack after release; the next fresh request completes normally.
- Throughout all tests: never both strobes high; each ack is exactly one cycle long and goes only to the granted port.
